multi_blink_timer: RTL and testbench
====================================

# multi_blink_timer

Multi-channel, parameterised blink timer for the Blinking-LED core on the NEXYS4 DDR. It holds one independent period counter per LED channel and a per-channel mode of off, solid, blink or one-shot. Each channel drives a registered LED level and a one-cycle tick strobe. It sits between the register/control logic, which supplies the periods and modes, and the board LED pins.

## Interface
Parameters:
- `NCH`, 4: number of channels.
- `W`, 27: width of each channel's period and counter.
- `PRESCALE`, 1000: shared clock divider ratio. Used only when `MULTI_BLINK_PRESCALE_EN` is defined; must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `period`  in  NCH*W  packed per-channel period value P; channel i occupies bits [i*W +: W].
- `mode`  in  2*NCH  packed per-channel mode; channel i occupies bits [2i +: 2]. 00 off, 01 solid, 10 blink, 11 one-shot.
- `led`  out  NCH  registered LED level per channel.
- `tick`  out  NCH  registered one-cycle strobe, asserted at each period end.

## Operation
- State per channel: counter `cnt` (W bits), registered mode copy `mode_q`, one-shot `done` flag.
- `adv`: advance strobe. Constant 1 without the prescaler; with the prescaler, the one-cycle prescale strobe.
- Mode change (`mode` ≠ `mode_q`), which has priority over all other behaviour:
  - `cnt` ← 0, `done` ← 0, `tick` ← 0.
  - `led` ← 0 for modes 00 and 10; `led` ← 1 for modes 01 and 11.
  - `mode_q` ← `mode`.
- Mode 00 (off): `cnt` held at 0, `led` = 0, `tick` = 0.
- Mode 01 (solid): `cnt` held at 0, `led` = 1, `tick` = 0.
- Mode 10 (blink), on a cycle with `adv`:
  - If `cnt` ≥ P: `cnt` ← 0, `tick` ← 1, `led` toggles.
  - Otherwise: `cnt` ← `cnt`+1, `tick` ← 0.
  - Resulting period is P+1 advances; full LED cycle is 2(P+1) advances.
- Mode 11 (one-shot):
  - `led` = 1 and `cnt` counts as in blink.
  - On the first `cnt` ≥ P: `led` ← 0, `tick` ← 1 for one cycle, `done` ← 1.
  - While `done` = 1: `cnt` frozen, `led` = 0, `tick` = 0.
  - Re-arming requires leaving mode 11 and re-entering it.
- The comparison is ≥, not ==. If P is lowered below the current `cnt` mid-count, the period ends on the next `adv`; there is no wrap through 2^W.
- P = 0: in blink, `tick` every `adv` and `led` toggles every `adv`.
- `cnt` never exceeds max(P, previous `cnt`). It cannot overflow because `cnt` ≤ P ≤ 2^W−1 before it clears.
- `period` is sampled every cycle; no load strobe. The new P takes effect on the next compare.
- Channels are fully independent; they share nothing except `adv`.

## Timing
- Reset (`rst`=1 at an edge): all `cnt` = 0, `led` = 0, `tick` = 0, `done` = 0, `mode_q` = 00, prescaler = 0.
- First cycle after reset release: a non-00 `mode` counts as a mode change.
- Reset mid-operation aborts all channels in the same edge.
- `tick[i]` is high for exactly one cycle. It coincides with the first cycle of the new `led[i]` level.
- Blink, no prescaler, mode set at edge 0: `tick` first high after edge P+1, then every P+1 cycles.
- Mode change and period end on the same cycle: the mode change wins and no tick is issued.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Configuration
- `MULTI_BLINK_PRESCALE_EN` defined:
  - A shared counter runs 0…PRESCALE−1 and emits `adv` for one cycle when it wraps.
  - Channel counters advance only on `adv`. Mode-change handling still occurs on any cycle.
- Not defined: `adv` = 1 every cycle, `PRESCALE` is ignored, and no prescaler logic is synthesised.

## Test plan
- Reset → `led` = 0, `tick` = 0 on all channels; hold `rst` high 3 cycles with mode = 10 on all → outputs stay 0.
- Ch0 blink, P = 3, no prescaler → `tick[0]` pulses every 4 cycles; `led[0]` reads 0000111100001111… starting at the mode edge.
- Ch1 one-shot, P = 5 → `led[1]` high for 6 cycles, one `tick[1]`, then low indefinitely; mode 11→00→11 → re-armed with 6 cycles high again.
- Ch2 blink P = 100, drop P to 2 when `cnt` = 50 → `tick` on the next cycle, then every 3 cycles.
- Ch3 P = 0 blink → `led[3]` toggles every cycle and `tick[3]` is constant 1; a mode change to 01 → `led` = 1, `tick` = 0 from the next cycle.
- `MULTI_BLINK_PRESCALE_EN` defined with PRESCALE = 4, P = 1 → `tick` every 8 cycles; asserting `rst` mid-period clears all counters and outputs on the next edge.

Source files
------------

// File: rtl/multi_blink_timer.sv
// Multi-channel blink timer: per-channel off / solid / blink / one-shot LED modes with tick strobes.
// Optional shared prescaler enabled by defining MULTI_BLINK_PRESCALE_EN.
module multi_blink_timer #(
    parameter int NCH      = 4,
    parameter int W        = 27,
    parameter int PRESCALE = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH*W-1:0]   period,
    input  logic [2*NCH-1:0]   mode,
    output logic [NCH-1:0]     led,
    output logic [NCH-1:0]     tick
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_SOLID = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;

    logic adv;

`ifdef MULTI_BLINK_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_reg;

    assign adv = (pre_reg == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg <= '0;
        end else if (adv) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + PW'(1);
        end
    end
`else
    assign adv = 1'b1;
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [W-1:0] p_val;
            logic [1:0]   m_val;
            logic [W-1:0] cnt_reg, cnt_next;
            logic [1:0]   mode_reg, mode_next;
            logic         done_reg, done_next;
            logic         led_reg, led_next;
            logic         tick_reg, tick_next;

            assign p_val = period[gi*W +: W];
            assign m_val = mode[2*gi +: 2];

            always_comb begin
                cnt_next  = cnt_reg;
                mode_next = mode_reg;
                done_next = done_reg;
                led_next  = led_reg;
                tick_next = 1'b0;
                if (m_val != mode_reg) begin
                    // Mode change wins over any period end on the same cycle.
                    cnt_next  = '0;
                    done_next = 1'b0;
                    led_next  = m_val[0];
                    mode_next = m_val;
                end else begin
                    case (mode_reg)
                        MODE_OFF: begin
                            cnt_next = '0;
                            led_next = 1'b0;
                        end
                        MODE_SOLID: begin
                            cnt_next = '0;
                            led_next = 1'b1;
                        end
                        MODE_BLINK: begin
                            if (adv) begin
                                // >= so a lowered period ends promptly instead of wrapping.
                                if (cnt_reg >= p_val) begin
                                    cnt_next  = '0;
                                    tick_next = 1'b1;
                                    led_next  = ~led_reg;
                                end else begin
                                    cnt_next = cnt_reg + W'(1);
                                end
                            end
                        end
                        default: begin
                            if (done_reg) begin
                                led_next = 1'b0;
                            end else begin
                                led_next = 1'b1;
                                if (adv) begin
                                    if (cnt_reg >= p_val) begin
                                        cnt_next  = '0;
                                        tick_next = 1'b1;
                                        led_next  = 1'b0;
                                        done_next = 1'b1;
                                    end else begin
                                        cnt_next = cnt_reg + W'(1);
                                    end
                                end
                            end
                        end
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg  <= '0;
                    mode_reg <= MODE_OFF;
                    done_reg <= 1'b0;
                    led_reg  <= 1'b0;
                    tick_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    mode_reg <= mode_next;
                    done_reg <= done_next;
                    led_reg  <= led_next;
                    tick_reg <= tick_next;
                end
            end

            assign led[gi]  = led_reg;
            assign tick[gi] = tick_reg;
        end
    endgenerate

endmodule

// File: tb/tb_multi_blink_timer.sv
// Self-checking bench for multi_blink_timer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural channel model.
module tb_multi_blink_timer;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int PS  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NCH*W-1:0]   period = '0;
    logic [2*NCH-1:0]   mode = '0;
    logic [NCH-1:0]     led;
    logic [NCH-1:0]     tick;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_mode [NCH];
    int m_cnt  [NCH];
    bit m_done [NCH];
    bit m_led  [NCH];
    bit m_tick [NCH];
    int m_pre;

    multi_blink_timer #(.NCH(NCH), .W(W), .PRESCALE(PS)) dut (
        .clk    (clk),
        .rst    (rst),
        .period (period),
        .mode   (mode),
        .led    (led),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [2*NCH-1:0] mkm(input int ch, input logic [1:0] md);
        logic [2*NCH-1:0] v;
        v = '0;
        v[2*ch +: 2] = md;
        return v;
    endfunction

    function automatic logic [NCH*W-1:0] mkp(input int ch, input int p);
        logic [NCH*W-1:0] v;
        v = '0;
        v[ch*W +: W] = W'(p);
        return v;
    endfunction

    task automatic model_update(input logic r, input logic [NCH*W-1:0] p, input logic [2*NCH-1:0] m);
        bit adv;
        if (r) begin
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_led[i] = 0; m_tick[i] = 0;
            end
            m_pre = 0;
            return;
        end
`ifdef MULTI_BLINK_PRESCALE_EN
        adv = (m_pre == PS - 1);
        m_pre = adv ? 0 : m_pre + 1;
`else
        adv = 1'b1;
`endif
        for (int i = 0; i < NCH; i++) begin
            int md;
            int pv;
            md = int'(m[2*i +: 2]);
            pv = int'(p[i*W +: W]);
            m_tick[i] = 0;
            if (md != m_mode[i]) begin
                m_mode[i] = md;
                m_cnt[i]  = 0;
                m_done[i] = 0;
                m_led[i]  = (md == 1 || md == 3);
            end else if (md == 0 || md == 1) begin
                m_cnt[i] = 0;
                m_led[i] = (md == 1);
            end else if (m_done[i]) begin
                m_led[i] = 0;
            end else begin
                if (md == 3) m_led[i] = 1;
                if (adv) begin
                    if (m_cnt[i] >= pv) begin
                        m_cnt[i]  = 0;
                        m_tick[i] = 1;
                        if (md == 2) begin
                            m_led[i] = !m_led[i];
                        end else begin
                            m_led[i]  = 0;
                            m_done[i] = 1;
                        end
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, then compare every channel after the edge.
    task automatic step(input logic r, input logic [NCH*W-1:0] p, input logic [2*NCH-1:0] m);
        rst = r;
        period = p;
        mode = m;
        model_update(r, p, m);
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (led[i] !== m_led[i] || tick[i] !== m_tick[i]) begin
                errors++;
                $display("FAIL model ch%0d: led=%b tick=%b expected led=%b tick=%b at %0t",
                         i, led[i], tick[i], m_led[i], m_tick[i], $time);
            end
        end
    endtask

    initial begin
        logic [NCH*W-1:0] cur_p;
        logic [2*NCH-1:0] cur_m;
        logic             r;

        for (int k = 0; k < 3; k++) begin
            step(1'b1, {NCH{W'(3)}}, {NCH{2'b10}});
            lit("reset_led", 32'(led), 32'd0);
            lit("reset_tick", 32'(tick), 32'd0);
        end

`ifndef MULTI_BLINK_PRESCALE_EN
        for (int k = 0; k < 12; k++) begin
            step(1'b0, mkp(0, 3), mkm(0, 2'b10));
            lit("ch0_blink_led", 32'(led[0]), 32'((k / 4) % 2));
            lit("ch0_blink_tick", 32'(tick[0]), 32'(k > 0 && k % 4 == 0));
        end

        for (int k = 0; k < 16; k++) begin
            step(1'b0, mkp(1, 5), mkm(1, 2'b11));
            lit("ch1_oneshot_led", 32'(led[1]), 32'(k < 6));
            lit("ch1_oneshot_tick", 32'(tick[1]), 32'(k == 6));
        end
        step(1'b0, mkp(1, 5), '0);
        lit("ch1_off_led", 32'(led[1]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, mkp(1, 5), mkm(1, 2'b11));
            lit("ch1_rearm_led", 32'(led[1]), 32'(k < 6));
            lit("ch1_rearm_tick", 32'(tick[1]), 32'(k == 6));
        end

        for (int k = 0; k < 58; k++) begin
            step(1'b0, mkp(2, (k <= 50) ? 100 : 2), mkm(2, 2'b10));
            lit("ch2_drop_tick", 32'(tick[2]), 32'(k >= 51 && (k - 51) % 3 == 0));
        end

        for (int k = 0; k < 6; k++) begin
            step(1'b0, mkp(3, 0), mkm(3, 2'b10));
            lit("ch3_p0_led", 32'(led[3]), 32'(k % 2));
            lit("ch3_p0_tick", 32'(tick[3]), 32'(k >= 1));
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b0, mkp(3, 0), mkm(3, 2'b01));
            lit("ch3_solid_led", 32'(led[3]), 32'd1);
            lit("ch3_solid_tick", 32'(tick[3]), 32'd0);
        end
`else
        step(1'b1, '0, '0);
        for (int k = 0; k < 17; k++) begin
            step(1'b0, mkp(0, 1), mkm(0, 2'b10));
            lit("pre_tick", 32'(tick[0]), 32'(k == 7 || k == 15));
        end
        step(1'b1, mkp(0, 1), mkm(0, 2'b10));
        lit("pre_rst_led", 32'(led), 32'd0);
        lit("pre_rst_tick", 32'(tick), 32'd0);
`endif

        cur_p = '0;
        cur_m = '0;
        for (int k = 0; k < 4000; k++) begin
            r = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 39) == 0) cur_m[2*i +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 29) == 0)
                    cur_p[i*W +: W] = W'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 40)
                                                                    : $urandom_range(0, 7));
            end
            step(r, cur_p, cur_m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
